// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined execute-stage ALU.
//   - 3-bit alu_op encodings
//   - FSM state encoding for the handshake controller
package alu_pkg;

  localparam logic [2:0] OP_OR  = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_CMP = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative N-bit unsigned shift-add multiplier.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : latch a/b and begin; ignored while running
//   a, b       : operands
//   done       : high during the cycle whose rising edge performs iteration N
//   prod_lo/hi : product after the iteration performed at the next edge;
//                equal to the full 2N-bit product while done is high
module alu_mul_iter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         done,
  output logic [N-1:0] prod_lo,
  output logic [N-1:0] prod_hi
);

  localparam int CW = $clog2(N) + 1;

  logic          run_q;
  logic [CW-1:0] cnt_q;
  logic [N-1:0]  a_q;
  logic [N-1:0]  hi_q;
  logic [N-1:0]  lo_q;

  logic [N:0]    sum;
  logic [N-1:0]  hi_d;
  logic [N-1:0]  lo_d;

  // Classic right-shifting product register: lo starts as the multiplier and
  // is consumed one bit per step while product bits shift in from the top.
  always_comb begin
    sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    hi_d = sum[N:1];
    lo_d = {sum[0], lo_q[N-1:1]};
  end

  // cnt_q holds the number of completed iterations, so N-1 means the next
  // edge performs the last one.
  assign done    = run_q && (cnt_q == CW'(N - 1));
  assign prod_lo = lo_d;
  assign prod_hi = hi_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      a_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else if (start && !run_q) begin
      run_q <= 1'b1;
      cnt_q <= '0;
      a_q   <= a;
      hi_q  <= '0;
      lo_q  <= b;
    end else if (run_q) begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_q + CW'(1);
      if (done) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Registered execute-stage ALU with valid/ready handshake and flag register.
//   clk, rst_n      : clock, asynchronous active-low reset
//   in_valid        : operation request, accepted when in_ready is high
//   in_ready        : high in IDLE; low while a MUL iterates
//   alu_op          : OR/ADD/SUB/CMP/AND/SLL/SRL/MUL (see alu_pkg)
//   input_1/2       : operands A/B; shifts use only input_2[$clog2(N)-1:0]
//   out_valid       : one-cycle pulse per completed op
//   output_0        : result, held until the next completion
//   *_flag          : zero/negative/carry/overflow, updated only on completion
module alu_pipe
  import alu_pkg::*;
#(
  parameter int N          = 32,
  parameter bit SIGNED_CMP = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [2:0]   alu_op,
  input  logic [N-1:0] input_1,
  input  logic [N-1:0] input_2,
  output logic         out_valid,
  output logic [N-1:0] output_0,
  output logic         zero_flag,
  output logic         negative_flag,
  output logic         carry_flag,
  output logic         overflow_flag
);

  localparam int SW = $clog2(N);

  state_t        state_q, state_d;
  logic          accept;
  logic          is_mul;
  logic          mul_done;
  logic [N-1:0]  mul_lo;
  logic [N-1:0]  mul_hi;

  logic [SW-1:0] shamt;
  logic [N:0]    add_ext, sub_ext, sll_ext, srl_ext;
  logic [N-1:0]  res;
  logic          res_z, res_n, res_c, res_v;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (alu_op == OP_MUL);
  assign shamt    = input_2[SW-1:0];

  alu_mul_iter #(.N(N)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && is_mul),
    .a       (input_1),
    .b       (input_2),
    .done    (mul_done),
    .prod_lo (mul_lo),
    .prod_hi (mul_hi)
  );

  // One extra bit on each side of the shifters captures the last bit shifted
  // out; a zero shift leaves that bit at 0.
  assign add_ext = {1'b0, input_1} + {1'b0, input_2};
  assign sub_ext = {1'b0, input_1} - {1'b0, input_2};
  assign sll_ext = {1'b0, input_1} << shamt;
  assign srl_ext = {input_1, 1'b0} >> shamt;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave a latch behind.
  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    unique case (alu_op)
      OP_OR:  res = input_1 | input_2;
      OP_AND: res = input_1 & input_2;
      OP_ADD: begin
        res   = add_ext[N-1:0];
        res_c = add_ext[N];
        res_v = (input_1[N-1] == input_2[N-1]) && (res[N-1] != input_1[N-1]);
      end
      OP_SUB: begin
        res   = sub_ext[N-1:0];
        res_c = sub_ext[N];
        res_v = (input_1[N-1] != input_2[N-1]) && (res[N-1] != input_1[N-1]);
      end
      OP_CMP: begin
        res   = {{(N-1){1'b0}}, input_1 == input_2};
        res_c = input_1 < input_2;
      end
      OP_SLL: begin
        res   = sll_ext[N-1:0];
        res_c = sll_ext[N];
      end
      OP_SRL: begin
        res   = srl_ext[N:1];
        res_c = srl_ext[0];
      end
      default: ;
    endcase
    res_z = (res == '0);
    res_n = res[N-1];
    if (alu_op == OP_CMP) begin
      res_z = (input_1 == input_2);
      res_n = SIGNED_CMP ? ($signed(input_1) < $signed(input_2))
                         : (input_1 < input_2);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept && is_mul) state_d = BUSY;
      BUSY: if (mul_done)         state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the result and flag registers are reset too, because their reset
  // value of 0 is architecturally visible right after rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      output_0      <= '0;
      zero_flag     <= 1'b0;
      negative_flag <= 1'b0;
      carry_flag    <= 1'b0;
      overflow_flag <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept && !is_mul) begin
        out_valid     <= 1'b1;
        output_0      <= res;
        zero_flag     <= res_z;
        negative_flag <= res_n;
        carry_flag    <= res_c;
        overflow_flag <= res_v;
      end else if (state_q == BUSY && mul_done) begin
        out_valid     <= 1'b1;
        output_0      <= mul_lo;
        zero_flag     <= (mul_lo == '0);
        negative_flag <= mul_lo[N-1];
        carry_flag    <= (mul_hi != '0);
        overflow_flag <= 1'b0;
      end
    end
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Registered, parameter-width successor to the combinational execute-stage ALU.
- Widens the op set to 8 ops and keeps a persistent flag register (zero, negative, carry, overflow) that only changes when an op completes.
- Single-cycle ops return their result one clock after acceptance. MUL runs as an iterative shift-add multiply and stalls the issuer through a valid/ready handshake.
- Sits between the ID/EX pipeline register and EX/MEM. Hazard logic consumes the in_ready signal.

Parameters:
- N, 32, operand/result width; power of 2, minimum 8.
- SIGNED_CMP, 1, 1: CMP negative flag uses a signed less-than; 0: unsigned less-than.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept; high in IDLE
- alu_op  in  3  000 OR, 001 ADD, 010 SUB, 011 CMP, 100 AND, 101 SLL, 110 SRL, 111 MUL
- input_1  in  N  operand A
- input_2  in  N  operand B; for shifts only bits [$clog2(N)-1:0] are used
- out_valid  out  1  one-cycle pulse when result is valid
- output_0  out  N  result; holds its value until the next completion
- zero_flag  out  1  registered flag
- negative_flag  out  1  registered flag
- carry_flag  out  1  registered flag
- overflow_flag  out  1  registered flag

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE, in_ready=1, out_valid=0, output_0=0, all flags=0.
  - Reset in the middle of a MUL aborts it; no out_valid is produced for the aborted op.
- Accept: at a rising edge where in_valid && in_ready. in_valid while in_ready=0 is ignored and not queued.
- Single-cycle ops:
  - Result and flags register at the accept edge; out_valid=1 for the following cycle (latency 1).
  - Back-to-back acceptance every cycle is allowed.
- OR/AND: bitwise. zero = (result==0), negative = result[N-1], carry=0, overflow=0.
- ADD:
  - result = A+B mod 2^N; carry = bit N of the (N+1)-bit sum.
  - overflow = (A[N-1]==B[N-1]) && (result[N-1]!=A[N-1]).
  - zero and negative are taken from the result.
- SUB:
  - result = A-B mod 2^N; carry = borrow = (A<B unsigned).
  - overflow = (A[N-1]!=B[N-1]) && (result[N-1]!=A[N-1]).
- CMP:
  - result = {N-1 zeros, A==B}; zero = (A==B).
  - negative = A<B (signed if SIGNED_CMP, else unsigned).
  - carry = unsigned A<B; overflow=0.
- SLL/SRL:
  - Logical shift by input_2[$clog2(N)-1:0].
  - carry = last bit shifted out; it is 0 for a shift of 0.
  - overflow=0; zero and negative from the result.
- MUL:
  - Accept edge t latches the operands; state goes IDLE→BUSY and in_ready=0.
  - One shift-add iteration per edge at t+1 .. t+N.
  - At edge t+N: state→IDLE, output_0 = low N bits of A*B (unsigned), out_valid=1 in the cycle after t+N, in_ready=1 in that same cycle. A new op may therefore be accepted at edge t+N+1.
  - Flags: zero and negative from the result; carry = (high N product bits != 0); overflow=0.
- Flags and output_0 update only on completion and hold their values otherwise, including while BUSY.
- out_valid is never high for two consecutive cycles from a single op.
- State machine:
  - IDLE → BUSY on accepted MUL.
  - BUSY → IDLE when the iteration count reaches N.
  - Any state → IDLE on reset.
- Iteration counter width: $clog2(N)+1.

Decomposition:
- Shared package alu_pkg holds:
  - the alu_op localparams OR/ADD/SUB/CMP/AND/SLL/SRL/MUL (3-bit);
  - the FSM state encoding IDLE/BUSY.
- One natural sub-module, alu_mul_iter: an N-bit shift-add multiplier with start/done, product low/high outputs, and its own counter.
- alu_pipe contains the combinational single-cycle datapath, the flag logic, the handshake, and the output registers.

Test Plan:
- Reset then ADD A=0xFFFFFFFF, B=1 → one cycle later out_valid=1, output_0=0, zero=1, carry=1, overflow=0, negative=0.
- SUB A=0x80000000, B=1 → output_0=0x7FFFFFFF, overflow=1, carry=0, negative=0; then CMP A=5, B=7 → output_0=0, zero=0, negative=1, carry=1.
- CMP A=0xFFFFFFFF, B=1 with SIGNED_CMP=1 → negative=1; same stimulus with SIGNED_CMP=0 → negative=0; CMP 7,7 → output_0=1, zero=1.
- MUL A=1234, B=5678 → in_ready=0 for 32 cycles; in_valid pulses during that window are ignored; then out_valid after edge t+32, output_0=7006652, carry=0, and flags unchanged before completion.
- rst_n low asynchronously at iteration 10 of MUL → in_ready=1 and all outputs 0 immediately; no out_valid afterwards; next ADD 2+3 → 5.
- SLL A=0x80000001, B=1 → output_0=0x00000002, carry=1; then 4 back-to-back ADDs (1+1, 2+2, 3+3, 4+4) on consecutive cycles → out_valid high 4 consecutive cycles with results 2, 4, 6, 8.
